// File: rtl/gpu_pkg.sv
// Shared register-file definitions for the GPU/DSP operand path.
//   RF_AW / RF_DW : register-file address and data widths
//   rf_addr_t     : {bank, reg[4:0]} address
//   rf_addr()     : builds a register-file address from bank and register number
package gpu_pkg;
    localparam int RF_AW = 6;
    localparam int RF_DW = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;

    function automatic rf_addr_t rf_addr(input logic bank, input logic [4:0] rnum);
        return {bank, rnum};
    endfunction
endpackage

// File: rtl/gpu_fwd_mux.sv
// Write-back forwarding select for one operand.
//   fwd_en/fwd_addr/fwd_data : write-back seen in the cycle the RAM read was issued
//   addr                     : address that read was for
//   rd_data                  : word returned by the RAM (stale on a same-cycle write)
//   data                     : forwarded or RAM data
import gpu_pkg::*;

module gpu_fwd_mux #(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          fwd_en,
    input  logic [AW-1:0] fwd_addr,
    input  logic [DW-1:0] fwd_data,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] data
);
    // Full address compare, so the bank bit takes part in the match.
    assign data = (fwd_en && (fwd_addr == addr)) ? fwd_data : rd_data;
endmodule

// File: rtl/gpu_operand_fetch.sv
// Operand-fetch stage in front of the 64x32 dual-port register file.
// Pipeline: S0 (addresses driven from in_*) -> S1 (RAM data + forwarding) -> OUT (registered).
//   sys_clk, resetl          : clock, async active-low reset
//   in_valid/in_ready        : issue handshake; in_bank/in_srca/in_srcb/in_useb describe the sources
//   wb_en/wb_addr/wb_data    : write-back request, always owns RAM port B
//   rf_aa/rf_ab/rf_nwea/rf_nweb/rf_db/rf_qa/rf_qb : RAM ports (read data one clock after address)
//   out_valid/out_ready      : ALU handshake; out_opa/out_opb operands (out_opb=0 when B unused)
import gpu_pkg::*;

module gpu_operand_fetch #(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bank,
    input  logic [4:0]    in_srca,
    input  logic [4:0]    in_srcb,
    input  logic          in_useb,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [AW-1:0] rf_aa,
    output logic [AW-1:0] rf_ab,
    output logic          rf_nwea,
    output logic          rf_nweb,
    output logic [DW-1:0] rf_db,
    input  logic [DW-1:0] rf_qa,
    input  logic [DW-1:0] rf_qb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_opa,
    output logic [DW-1:0] out_opb
);
    logic          wb_go;
    logic          s1_valid, s1_useb, s1_stall, load_out, accept;
    logic [AW-1:0] s1_aa, s1_ab, src_aa, src_ab;
    logic          fwd_en, rd_b;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data, b_keep, s1_rdb, s1_fa, s1_fb, s1_opb;

    // A write-back is suppressed while reset is held so nothing reaches the RAM.
    assign wb_go    = wb_en & resetl;

    assign s1_stall = s1_valid & out_valid & ~out_ready;
    assign load_out = s1_valid & ~s1_stall;
    assign in_ready = ~(wb_go & in_useb) & ~s1_stall;
    assign accept   = in_valid & in_ready;

    assign src_aa   = rf_addr(in_bank, in_srca);
    assign src_ab   = rf_addr(in_bank, in_srcb);

    // While S1 is stalled its addresses are re-read every cycle so writes
    // landing during the stall are observed; write-back still wins port B.
    always_comb begin
        rf_aa = '0;
        rf_ab = '0;
        if (resetl) begin
            rf_aa = s1_stall ? s1_aa : src_aa;
            if (wb_go)         rf_ab = wb_addr;
            else if (s1_stall) rf_ab = s1_ab;
            else               rf_ab = src_ab;
        end
    end

    assign rf_nwea = 1'b1;
    assign rf_nweb = ~wb_go;
    assign rf_db   = wb_data;

    // If port B was taken by a write-back last cycle, rf_qb is not ours:
    // fall back on the B word captured the cycle before.
    assign s1_rdb = rd_b ? rf_qb : b_keep;

    gpu_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_a (
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .addr(s1_aa), .rd_data(rf_qa), .data(s1_fa)
    );

    gpu_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_b (
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .addr(s1_ab), .rd_data(s1_rdb), .data(s1_fb)
    );

    assign s1_opb = s1_useb ? s1_fb : '0;

    // Write-back of the read cycle, replayed against the data returned next cycle
    // (the RAM returns OLD_DATA on a same-cycle read/write).
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            fwd_en   <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
            rd_b     <= 1'b1;
            b_keep   <= '0;
        end else begin
            fwd_en   <= wb_en;
            fwd_addr <= wb_addr;
            fwd_data <= wb_data;
            rd_b     <= ~wb_en;
            if (s1_valid) b_keep <= s1_fb;
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            s1_valid <= 1'b0;
            s1_useb  <= 1'b0;
            s1_aa    <= '0;
            s1_ab    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_useb  <= in_useb;
            s1_aa    <= src_aa;
            s1_ab    <= src_ab;
        end else if (load_out) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            out_valid <= 1'b0;
            out_opa   <= '0;
            out_opb   <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_opa   <= s1_fa;
            out_opb   <= s1_opb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gpu_operand_fetch.sv
// Directed bench for gpu_operand_fetch with a behavioural OLD_DATA register file
// and an expected-operand queue drained by a monitor process.
module tb_gpu_operand_fetch;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        in_valid, in_ready, in_bank, in_useb;
    logic [4:0]  in_srca, in_srcb;
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  rf_aa, rf_ab;
    logic        rf_nwea, rf_nweb;
    logic [31:0] rf_db, rf_qa, rf_qb;
    logic        out_valid, out_ready;
    logic [31:0] out_opa, out_opb;

    logic [31:0] mem [0:63] = '{default: 32'h0};
    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    gpu_operand_fetch dut (
        .sys_clk(sys_clk), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready), .in_bank(in_bank),
        .in_srca(in_srca), .in_srcb(in_srcb), .in_useb(in_useb),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_aa(rf_aa), .rf_ab(rf_ab), .rf_nwea(rf_nwea), .rf_nweb(rf_nweb),
        .rf_db(rf_db), .rf_qa(rf_qa), .rf_qb(rf_qb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opa(out_opa), .out_opb(out_opb)
    );

    // Registered reads, OLD_DATA on a same-cycle write.
    always @(posedge sys_clk) begin
        rf_qa <= mem[rf_aa];
        rf_qb <= mem[rf_ab];
        if (!rf_nweb) mem[rf_ab] <= rf_db;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (resetl && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got opa=%h opb=%h expected nothing", out_opa, out_opb);
                end else begin
                    e = sbq.pop_front();
                    check("out_opa", out_opa, e.a);
                    check("out_opb", out_opb, e.b);
                end
            end
        end
    endtask

    // Present an op, wait (bounded) for in_ready, record the expectation at accept.
    task automatic issue(input logic bank, input logic [4:0] a, input logic [4:0] b,
                         input logic useb, input logic [31:0] ea, input logic [31:0] eb);
        int w;
        in_valid = 1'b1; in_bank = bank; in_srca = a; in_srcb = b; in_useb = useb;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            #1;
            w++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 20 cycles");
        end else begin
            sbq.push_back('{a: ea, b: eb});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic write(input logic [5:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    initial begin
        exp_t        ops [3];
        int          k, acc;
        logic        have_snap;
        logic [31:0] snap_a, snap_b;

        fork
            monitor();
        join_none

        resetl = 1'b1; in_valid = 1'b0; in_bank = 1'b0; in_srca = '0; in_srcb = '0;
        in_useb = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        #2 resetl = 1'b0;

        // Reset state, with a write-back request held to show it is blocked.
        wb_en = 1'b1; wb_addr = 6'h11; wb_data = 32'hFFFF_0000;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_opa", out_opa, 0);
        check("rst_out_opb", out_opb, 0);
        check("rst_rf_nweb", rf_nweb, 1);
        check("rst_rf_nwea", rf_nwea, 1);
        check("rst_rf_aa", rf_aa, 0);
        check("rst_rf_ab", rf_ab, 0);
        wb_en = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        step();
        resetl = 1'b1;
        step();

        // r3 written, read two cycles later; latency accept+2.
        write(6'h03, 32'h1234_5678);
        step();
        issue(0, 5'd3, 5'd0, 0, 32'h1234_5678, 32'h0);
        check("lat_s1_valid", out_valid, 0);
        step();
        check("lat_out_valid", out_valid, 1);

        // Same-cycle write-back to r5 forwarded; opb is 0 because B is unused.
        wb_en = 1'b1; wb_addr = 6'h05; wb_data = 32'hDEAD_BEEF;
        issue(0, 5'd5, 5'd5, 0, 32'hDEAD_BEEF, 32'h0);
        wb_en = 1'b0;
        step(); step();

        // Write-back held 3 cycles blocks an op that uses port B.
        in_valid = 1'b1; in_bank = 1'b0; in_srca = 5'd8; in_srcb = 5'd9; in_useb = 1'b1;
        wb_en = 1'b1; wb_addr = 6'h08; wb_data = 32'hA000_0008;
        #1 check("wb_block_c0", in_ready, 0);
        step(); wb_addr = 6'h09; wb_data = 32'hB000_0009;
        #1 check("wb_block_c1", in_ready, 0);
        step(); wb_addr = 6'h0A; wb_data = 32'hC000_000A;
        #1 check("wb_block_c2", in_ready, 0);
        check("wb_owns_ab", rf_ab, 6'h0A);
        step(); wb_en = 1'b0;
        #1 check("wb_release", in_ready, 1);
        sbq.push_back('{a: 32'hA000_0008, b: 32'hB000_0009});
        step(); in_valid = 1'b0;
        step(); step(); step();

        // Back-pressure: 5 stalled cycles, 3 ops offered.
        ops[0] = '{a: 32'h1234_5678, b: 32'hDEAD_BEEF};
        ops[1] = '{a: 32'hA000_0008, b: 32'hB000_0009};
        ops[2] = '{a: 32'hC000_000A, b: 32'h1234_5678};
        k = 0; acc = 0; have_snap = 1'b0; snap_a = '0; snap_b = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wb_en = (c == 4); wb_addr = 6'h21; wb_data = 32'h5A5A_5A5A;
            in_valid = 1'b1; in_bank = 1'b0; in_useb = 1'b1;
            case (k)
                0:       begin in_srca = 5'd3;  in_srcb = 5'd5; end
                1:       begin in_srca = 5'd8;  in_srcb = 5'd9; end
                default: begin in_srca = 5'd10; in_srcb = 5'd3; end
            endcase
            #1;
            if (out_valid) begin
                if (have_snap) begin
                    check("stall_opa_stable", out_opa, snap_a);
                    check("stall_opb_stable", out_opb, snap_b);
                end else begin
                    snap_a = out_opa; snap_b = out_opb; have_snap = 1'b1;
                end
            end
            if (in_ready) begin
                sbq.push_back(ops[k]);
                k++;
                acc++;
            end
            step();
        end
        wb_en = 1'b0;
        check("stall_accepted_le2", (acc <= 2), 1);
        out_ready = 1'b1;
        while (k < 3) begin
            issue(0, (k == 2) ? 5'd10 : 5'd8, (k == 2) ? 5'd3 : 5'd9, 1, ops[k].a, ops[k].b);
            k++;
        end
        step(); step(); step();

        // Bank isolation and bank-qualified forwarding.
        write(6'h07, 32'hAAAA_0000);
        write(6'h27, 32'h0000_BBBB);
        step();
        issue(1, 5'd7, 5'd7, 1, 32'h0000_BBBB, 32'h0000_BBBB);
        issue(0, 5'd7, 5'd0, 0, 32'hAAAA_0000, 32'h0);
        wb_en = 1'b1; wb_addr = 6'h2C; wb_data = 32'h0C0C_0C0C;
        issue(0, 5'd12, 5'd12, 0, 32'h0, 32'h0);
        wb_en = 1'b0;
        step(); step(); step();
        check("drain_empty", sbq.size(), 0);

        // Reset with OUT and S1 both occupied.
        out_ready = 1'b0;
        issue(0, 5'd3, 5'd5, 1, 32'h1234_5678, 32'hDEAD_BEEF);
        issue(0, 5'd8, 5'd9, 1, 32'hA000_0008, 32'hB000_0009);
        check("pre_rst_out_valid", out_valid, 1);
        wb_en = 1'b1; wb_addr = 6'h10; wb_data = 32'hFFFF_FFFF;
        #1 resetl = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_rf_nweb", rf_nweb, 1);
        check("midrst_out_opa", out_opa, 0);
        sbq.delete();
        step(); step();
        resetl = 1'b1; wb_en = 1'b0; out_ready = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);
        step(); step();
        check("post_rst_out_valid", out_valid, 0);
        check("no_write_in_reset", mem[16], 0);
        check("final_queue_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
